// File: rtl/imem_loader.sv
// imem_loader: serial program loader for the pipelined MIPS core.
// Receives a framed UART 8N1 byte stream (0xA5, count N, N*4 data bytes MSB
// first, optional XOR checksum) and writes big-endian 32-bit words into the
// instruction memory while holding the core in reset.
//
// Optional feature: define IMEM_LOADER_CSUM_EN to compile in the checksum
// byte check (CSUM state and XOR register).
//
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   rx         - asynchronous UART receive line (idles high)
//   imem_we    - one-cycle instruction-memory write strobe
//   imem_addr  - instruction-memory word address
//   imem_wdata - instruction word to write
//   core_reset - holds the pipeline in reset during a load
//   load_done  - one-cycle pulse on successful load completion
//   load_err   - sticky error flag (framing / checksum)
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
`ifdef IMEM_LOADER_CSUM_EN
  localparam logic [2:0] ST_CSUM  = 3'd3;
`endif
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // receiver state
  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] bit_timer;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid;
  logic             frame_err;

  // loader state
  logic [2:0]       state;
  logic [8:0]       word_cnt;
  logic [1:0]       byte_idx;
  logic [23:0]      assembler;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]       csum;
`endif

  // UART receiver: synchronizer, start-bit validation, mid-bit sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      bit_timer  <= '0;
      bit_idx    <= 3'd0;
      rx_shift   <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // edge-triggered so a line held low does not retrigger
          if (rx_prev && !rx_sync) begin
            rx_state  <= RX_START;
            bit_timer <= '0;
          end
        end
        RX_START: begin
          if (bit_timer == HALF_M1) begin
            bit_timer <= '0;
            bit_idx   <= 3'd0;
            // start bit gone high by mid-bit: treat as a glitch
            rx_state  <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            bit_timer <= bit_timer + T_ONE;
          end
        end
        RX_DATA: begin
          if (bit_timer == FULL_M1) begin
            bit_timer <= '0;
            rx_shift  <= {rx_sync, rx_shift[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            bit_timer <= bit_timer + T_ONE;
          end
        end
        RX_STOP: begin
          if (bit_timer == FULL_M1) begin
            bit_timer <= '0;
            rx_state  <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bit_timer <= bit_timer + T_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // frame FSM: header, count, word assembly, optional checksum, writes
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      word_cnt   <= 9'd0;
      byte_idx   <= 2'd0;
      assembler  <= 24'd0;
`ifdef IMEM_LOADER_CSUM_EN
      csum       <= 8'd0;
`endif
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      core_reset <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      // address advances the cycle after each strobe and wraps naturally
      if (imem_we) begin
        imem_addr <= imem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (frame_err) begin
        load_err <= 1'b1;
        state    <= ST_ERR;
      end else if (byte_valid) begin
        case (state)
          ST_IDLE, ST_ERR: begin
            if (rx_shift == HDR_BYTE) begin
              state      <= ST_COUNT;
              core_reset <= 1'b1;
              load_err   <= 1'b0;
              imem_addr  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
              csum       <= 8'd0;
`endif
            end
          end
          ST_COUNT: begin
            // a count of zero encodes 256 words
            word_cnt <= (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
            byte_idx <= 2'd0;
            state    <= ST_DATA;
          end
          ST_DATA: begin
            assembler <= {assembler[15:0], rx_shift};
            byte_idx  <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            csum      <= csum ^ rx_shift;
`endif
            if (byte_idx == 2'd3) begin
              imem_wdata <= {assembler, rx_shift};
              imem_we    <= 1'b1;
              word_cnt   <= word_cnt - 9'd1;
              if (word_cnt == 9'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
                state      <= ST_CSUM;
`else
                load_done  <= 1'b1;
                core_reset <= 1'b0;
                state      <= ST_IDLE;
`endif
              end
            end
          end
`ifdef IMEM_LOADER_CSUM_EN
          ST_CSUM: begin
            if (rx_shift == csum) begin
              load_done  <= 1'b1;
              core_reset <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              load_err <= 1'b1;
              state    <= ST_ERR;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
